fetch_queue: RTL

Instruction fetch front end placed between the instruction memory and the core's decode stage. It generates sequential fetch addresses, issues them to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes them through a valid/ready handshake, which replaces the core's fetch-stall path. A redirect input from branch/jump resolution flushes the buffer, discards any in-flight response, and restarts fetch at a new PC.

---
 rtl/fetch_queue.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential fetch address generation, one outstanding
// synchronous-read request, and a DEPTH-entry {pc, instr} FIFO feeding decode.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic [AW+1:0] credit_used;
   logic          push;
   logic          pop;

   // The credit check uses the pre-pop count plus the outstanding request, so every
   // response already has a reserved slot when it lands.
   assign credit_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
   assign imem_req    = rst_n && !redirect_valid && (credit_used < DEPTH_W);
   assign imem_addr   = fetch_pc;
   assign out_valid   = (count != '0) && !redirect_valid;
   assign out_pc      = pc_mem[rd_ptr];
   assign out_instr   = instr_mem[rd_ptr];
   assign push        = inflight && !redirect_valid;
   assign pop         = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
            wr_ptr            <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
